// File: rtl/adc_pkg.sv
// Shared types and constants for the ADS1115-class scan controller.
// The optional poll timeout is enabled with the ADC_TIMEOUT_EN macro (see adc_scanner).
package adc_pkg;

  // Byte-level I2C master instruction codes
  typedef enum logic [1:0] {
    I2C_START = 2'd0,
    I2C_STOP  = 2'd1,
    I2C_READ  = 2'd2,
    I2C_WRITE = 2'd3
  } i2c_instr_e;

  // One request to the I2C master
  typedef struct packed {
    i2c_instr_e  instr;
    logic [7:0]  data;
  } i2c_op_t;

  // ADC register pointers
  localparam logic [7:0] REG_CONVERSION = 8'h00;
  localparam logic [7:0] REG_CONFIG     = 8'h01;

  // Scan controller states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_SETTLE,
    ST_POLL,
    ST_PTR,
    ST_READ,
    ST_NEXT,
    ST_DONE
  } scan_state_e;

  // Single handshake states
  typedef enum logic [1:0] {
    STEP_IDLE,
    STEP_WAIT_LOW,
    STEP_WAIT_HIGH
  } step_state_e;

  // Config register field offsets within the high and low bytes
  localparam int unsigned CFG_OS_BIT   = 7;
  localparam int unsigned CFG_MUX_LSB  = 4;
  localparam int unsigned CFG_PGA_LSB  = 1;
  localparam int unsigned CFG_MODE_BIT = 0;
  localparam int unsigned CFG_DR_LSB   = 5;
  localparam logic [4:0]  CFG_LO_TAIL  = 5'b00011;

  // High config byte: start single conversion, AINx vs GND, PGA, single-shot mode
  function automatic logic [7:0] cfg_hi_byte(input logic [1:0] ch, input logic [2:0] pga);
    logic [7:0] b;
    b                  = 8'h00;
    b[CFG_OS_BIT]      = 1'b1;
    b[CFG_MUX_LSB+:3]  = {1'b1, ch};
    b[CFG_PGA_LSB+:3]  = pga;
    b[CFG_MODE_BIT]    = 1'b1;
    return b;
  endfunction

  // Low config byte: data rate, comparator disabled
  function automatic logic [7:0] cfg_lo_byte(input logic [2:0] dr);
    logic [7:0] b;
    b                 = 8'h00;
    b[CFG_DR_LSB+:3]  = dr;
    b[4:0]            = CFG_LO_TAIL;
    return b;
  endfunction

endpackage

// File: rtl/adc_i2c_step.sv
// One request/complete handshake with the byte-level I2C master.
module adc_i2c_step
  import adc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  i2c_op_t     op,
  output logic        done,
  output logic [7:0]  rx_byte,
  output logic [1:0]  instructionI2C,
  output logic        enableI2C,
  output logic [7:0]  byteToSendI2C,
  input  logic [7:0]  byteReceivedI2C,
  input  logic        completeI2C
);

  step_state_e state, state_d;
  logic        done_d, en_d;
  logic [1:0]  instr_d;
  logic [7:0]  tx_d, rx_d;

  // Next state: wait for complete to go low (request taken), then high (finished)
  always_comb begin
    state_d = state;
    done_d  = 1'b0;
    en_d    = enableI2C;
    instr_d = instructionI2C;
    tx_d    = byteToSendI2C;
    rx_d    = rx_byte;
    case (state)
      STEP_IDLE: begin
        if (start) begin
          instr_d = 2'(op.instr);
          tx_d    = op.data;
          en_d    = 1'b1;
          state_d = STEP_WAIT_LOW;
        end
      end
      STEP_WAIT_LOW: begin
        if (!completeI2C) state_d = STEP_WAIT_HIGH;
      end
      STEP_WAIT_HIGH: begin
        if (completeI2C) begin
          rx_d    = byteReceivedI2C;
          done_d  = 1'b1;
          en_d    = 1'b0;
          state_d = STEP_IDLE;
        end
      end
      default: state_d = STEP_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= STEP_IDLE;
      done           <= 1'b0;
      enableI2C      <= 1'b0;
      instructionI2C <= 2'd0;
      byteToSendI2C  <= 8'h00;
      rx_byte        <= 8'h00;
    end else begin
      state          <= state_d;
      done           <= done_d;
      enableI2C      <= en_d;
      instructionI2C <= instr_d;
      byteToSendI2C  <= tx_d;
      rx_byte        <= rx_d;
    end
  end

endmodule

// File: rtl/adc_scanner.sv
// Multi-channel single-shot scan controller for an ADS1115-class I2C ADC.
// Optional feature: define ADC_TIMEOUT_EN to bound OS polls per conversion.
module adc_scanner
  import adc_pkg::*;
#(
  parameter logic [6:0]  ADDRESS       = 7'h48,
  parameter int unsigned NUM_CHANNELS  = 4,
  parameter logic [2:0]  PGA           = 3'b001,
  parameter logic [2:0]  DATA_RATE     = 3'b111,
  parameter int unsigned SETTLE_CYCLES = 256
`ifdef ADC_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_POLLS = 64
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        continuous,
  output logic [15:0] sampleData,
  output logic [1:0]  sampleChannel,
  output logic        sampleValid,
  output logic        scanDone,
  output logic        busy,
  output logic        timeoutError,
  output logic [1:0]  instructionI2C,
  output logic        enableI2C,
  output logic [7:0]  byteToSendI2C,
  input  logic [7:0]  byteReceivedI2C,
  input  logic        completeI2C
);

  localparam int unsigned CNT_W   = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [1:0]  LAST_CH = 2'(NUM_CHANNELS - 1);

  scan_state_e      state, state_d;
  logic [1:0]       ch, ch_d;
  logic [2:0]       op_idx, op_idx_d;
  logic             pending, pending_d;
  logic [CNT_W-1:0] settle_cnt, settle_cnt_d;
  logic [15:0]      rd_word, rd_word_d;
  logic             cont, cont_d;
  logic [15:0]      data_d;
  logic [1:0]       chan_d;
  logic             valid_d, done_d, busy_d;
  logic             step_req_c, step_done;
  logic [7:0]       step_rx;
  i2c_op_t          cur_op_c;

`ifdef ADC_TIMEOUT_EN
  localparam int unsigned PW = $clog2(TIMEOUT_POLLS) + 1;
  logic [PW-1:0] polls, polls_d;
  logic          timeout_d;
`endif

  // I2C sequence for each transaction state, indexed by op number
  function automatic i2c_op_t op_at(input scan_state_e st, input logic [2:0] idx,
                                    input logic [1:0] c);
    i2c_op_t o;
    o = '{instr: I2C_STOP, data: 8'h00};
    case (idx)
      3'd0: o = '{instr: I2C_START, data: 8'h00};
      3'd1: o = '{instr: I2C_WRITE,
                  data: {ADDRESS, (st == ST_POLL || st == ST_READ) ? 1'b1 : 1'b0}};
      3'd2: begin
        if (st == ST_CFG)      o = '{instr: I2C_WRITE, data: REG_CONFIG};
        else if (st == ST_PTR) o = '{instr: I2C_WRITE, data: REG_CONVERSION};
        else                   o = '{instr: I2C_READ,  data: 8'h00};
      end
      3'd3: begin
        if (st == ST_CFG)      o = '{instr: I2C_WRITE, data: cfg_hi_byte(c, PGA)};
        else if (st != ST_PTR) o = '{instr: I2C_READ,  data: 8'h00};
      end
      3'd4: begin
        if (st == ST_CFG)      o = '{instr: I2C_WRITE, data: cfg_lo_byte(DATA_RATE)};
      end
      default: o = '{instr: I2C_STOP, data: 8'h00};
    endcase
    return o;
  endfunction

  // Index of the closing STOP for each transaction state
  function automatic logic [2:0] last_op(input scan_state_e st);
    case (st)
      ST_CFG:  return 3'd5;
      ST_PTR:  return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  assign cur_op_c = op_at(state, op_idx, ch);

  adc_i2c_step u_step (
    .clk             (clk),
    .rst             (rst),
    .start           (step_req_c),
    .op              (cur_op_c),
    .done            (step_done),
    .rx_byte         (step_rx),
    .instructionI2C  (instructionI2C),
    .enableI2C       (enableI2C),
    .byteToSendI2C   (byteToSendI2C),
    .byteReceivedI2C (byteReceivedI2C),
    .completeI2C     (completeI2C)
  );

  // Next-state and output logic for the scan sequence
  always_comb begin
    state_d      = state;
    ch_d         = ch;
    op_idx_d     = op_idx;
    pending_d    = pending;
    settle_cnt_d = settle_cnt;
    rd_word_d    = rd_word;
    cont_d       = cont;
    data_d       = sampleData;
    chan_d       = sampleChannel;
    valid_d      = 1'b0;
    done_d       = 1'b0;
    step_req_c   = 1'b0;
`ifdef ADC_TIMEOUT_EN
    polls_d      = polls;
    timeout_d    = timeoutError;
`endif
    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_CFG;
          ch_d     = 2'd0;
          op_idx_d = 3'd0;
          cont_d   = continuous;
`ifdef ADC_TIMEOUT_EN
          polls_d   = '0;
          timeout_d = 1'b0;
`endif
        end
      end
      ST_CFG, ST_POLL, ST_PTR, ST_READ: begin
        if (!pending) begin
          step_req_c = 1'b1;
          pending_d  = 1'b1;
        end else if (step_done) begin
          pending_d = 1'b0;
          if (cur_op_c.instr == I2C_READ) begin
            if (op_idx == 3'd2) rd_word_d[15:8] = step_rx;
            else                rd_word_d[7:0]  = step_rx;
          end
          if (op_idx != last_op(state)) begin
            op_idx_d = op_idx + 3'd1;
          end else begin
            op_idx_d = 3'd0;
            case (state)
              ST_CFG: begin
                state_d      = ST_SETTLE;
                settle_cnt_d = '0;
              end
              ST_POLL: begin
                if (rd_word[8 + CFG_OS_BIT]) begin
                  state_d = ST_PTR;
                end
`ifdef ADC_TIMEOUT_EN
                else if (polls == PW'(TIMEOUT_POLLS - 1)) begin
                  timeout_d = 1'b1;
                  data_d    = 16'h8000;
                  chan_d    = ch;
                  valid_d   = 1'b1;
                  done_d    = (ch == LAST_CH);
                  state_d   = ST_NEXT;
                end
`endif
                else begin
                  state_d      = ST_SETTLE;
                  settle_cnt_d = '0;
                end
`ifdef ADC_TIMEOUT_EN
                polls_d = polls + PW'(1);
`endif
              end
              ST_PTR: state_d = ST_READ;
              default: begin
                // Result goes out with its tag; scanDone rides with the last channel
                data_d  = rd_word;
                chan_d  = ch;
                valid_d = 1'b1;
                done_d  = (ch == LAST_CH);
                state_d = ST_NEXT;
              end
            endcase
          end
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          state_d      = ST_POLL;
        end else begin
          settle_cnt_d = settle_cnt + CNT_W'(1);
        end
      end
      ST_NEXT: begin
`ifdef ADC_TIMEOUT_EN
        polls_d = '0;
`endif
        if (ch == LAST_CH) begin
          ch_d    = 2'd0;
          state_d = (cont && enable) ? ST_CFG : ST_DONE;
        end else begin
          ch_d    = ch + 2'd1;
          state_d = ST_CFG;
        end
      end
      ST_DONE: begin
        if (!enable) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      ch            <= 2'd0;
      op_idx        <= 3'd0;
      pending       <= 1'b0;
      settle_cnt    <= '0;
      rd_word       <= 16'h0000;
      cont          <= 1'b0;
      sampleData    <= 16'h0000;
      sampleChannel <= 2'd0;
      sampleValid   <= 1'b0;
      scanDone      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_d;
      ch            <= ch_d;
      op_idx        <= op_idx_d;
      pending       <= pending_d;
      settle_cnt    <= settle_cnt_d;
      rd_word       <= rd_word_d;
      cont          <= cont_d;
      sampleData    <= data_d;
      sampleChannel <= chan_d;
      sampleValid   <= valid_d;
      scanDone      <= done_d;
      busy          <= busy_d;
    end
  end

`ifdef ADC_TIMEOUT_EN
  // Poll counter and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      polls        <= '0;
      timeoutError <= 1'b0;
    end else begin
      polls        <= polls_d;
      timeoutError <= timeout_d;
    end
  end
`else
  assign timeoutError = 1'b0;
`endif

endmodule

// File: tb/tb_adc_scanner.sv
// Directed bench for adc_scanner with a behavioural I2C master and ADC model.
module tb_adc_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        continuous = 1'b0;
  logic [15:0] sampleData;
  logic [1:0]  sampleChannel;
  logic        sampleValid, scanDone, busy, timeoutError;
  logic [1:0]  instructionI2C;
  logic        enableI2C;
  logic [7:0]  byteToSendI2C;
  logic [7:0]  byteReceivedI2C;
  logic        completeI2C;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_scanner #(
    .ADDRESS       (7'h48),
    .NUM_CHANNELS  (4),
    .PGA           (3'b001),
    .DATA_RATE     (3'b111),
    .SETTLE_CYCLES (16)
`ifdef ADC_TIMEOUT_EN
    , .TIMEOUT_POLLS (4)
`endif
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .continuous      (continuous),
    .sampleData      (sampleData),
    .sampleChannel   (sampleChannel),
    .sampleValid     (sampleValid),
    .scanDone        (scanDone),
    .busy            (busy),
    .timeoutError    (timeoutError),
    .instructionI2C  (instructionI2C),
    .enableI2C       (enableI2C),
    .byteToSendI2C   (byteToSendI2C),
    .byteReceivedI2C (byteReceivedI2C),
    .completeI2C     (completeI2C)
  );

  // ADC model state
  logic [7:0] m_ptr = 8'h00, m_hi = 8'h00, m_lo = 8'h00, cur_hi = 8'h00, cur_lo = 8'h00;
  logic       m_rw = 1'b0;
  logic [1:0] m_ch = 2'd0;
  int         m_bidx = 0;
  int         m_zero_left = 0;
  int         zero_polls = 0;
  int         stuck_ch = -1;
  int         poll_cnt[4];
  int         addr_bad = 0;
  logic [7:0] cfg_hi_q[$];
  logic [7:0] cfg_lo_q[$];

  // Master model state
  logic m_busy = 1'b0;
  logic m_armed = 1'b1;
  int   m_cnt = 0;

  // Observed results
  logic [15:0] s_data[$];
  logic [1:0]  s_chan[$];
  int          done_cnt = 0;

  task automatic model_op(input logic [1:0] ins, input logic [7:0] b, output logic [7:0] rx);
    logic        os;
    logic [15:0] word;
    rx = 8'h00;
    case (ins)
      2'd0: m_bidx = 0;
      2'd3: begin
        if (m_bidx == 0) begin
          if (b[7:1] != 7'h48) addr_bad++;
          m_rw = b[0];
        end else if (m_bidx == 1) m_ptr = b;
        else if (m_bidx == 2) m_hi = b;
        else if (m_bidx == 3) m_lo = b;
        m_bidx++;
      end
      2'd2: begin
        if (m_ptr == 8'h01) begin
          if (m_bidx == 1) begin
            os = 1'b1;
            poll_cnt[m_ch]++;
            if (stuck_ch == int'(m_ch)) os = 1'b0;
            else if (m_zero_left > 0) begin
              m_zero_left--;
              os = 1'b0;
            end
            rx = {os, cur_hi[6:0]};
          end else begin
            rx = cur_lo;
          end
        end else begin
          word = 16'h1234 + 16'(m_ch);
          rx = (m_bidx == 1) ? word[15:8] : word[7:0];
        end
        m_bidx++;
      end
      default: begin
        if (!m_rw && m_bidx == 4 && m_ptr == 8'h01) begin
          cur_hi      = m_hi;
          cur_lo      = m_lo;
          m_ch        = m_hi[5:4];
          m_zero_left = zero_polls;
          cfg_hi_q.push_back(m_hi);
          cfg_lo_q.push_back(m_lo);
        end
      end
    endcase
  endtask

  // Behavioural I2C master sharing rst with the DUT
  initial begin
    logic [7:0] rx;
    completeI2C     <= 1'b1;
    byteReceivedI2C <= 8'h00;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        completeI2C <= 1'b1;
        m_busy  = 1'b0;
        m_armed = 1'b1;
        m_bidx  = 0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          model_op(instructionI2C, byteToSendI2C, rx);
          byteReceivedI2C <= rx;
          completeI2C     <= 1'b1;
          m_busy = 1'b0;
        end else begin
          m_cnt--;
        end
      end else if (enableI2C && m_armed) begin
        m_busy  = 1'b1;
        m_armed = 1'b0;
        m_cnt   = 3;
        completeI2C <= 1'b0;
      end else if (!enableI2C) begin
        m_armed = 1'b1;
      end
    end
  end

  // Output monitor
  always @(negedge clk) begin
    if (sampleValid) begin
      s_data.push_back(sampleData);
      s_chan.push_back(sampleChannel);
    end
    if (scanDone) done_cnt++;
  end

  task automatic clear_logs();
    s_data.delete();
    s_chan.delete();
    cfg_hi_q.delete();
    cfg_lo_q.delete();
    done_cnt = 0;
    for (int i = 0; i < 4; i++) poll_cnt[i] = 0;
  endtask

  task automatic wait_samples(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (s_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (s_data.size() < n) begin
      errors++;
      $display("FAIL %s: samples=%0d required=%0d (cycle budget expired)", tag, s_data.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k;
    k = 0;
    while (busy && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: busy=%b required=0 (cycle budget expired)", tag, busy);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks += 9;
    if (busy !== 1'b0)           begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (sampleValid !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", sampleValid); end
    if (scanDone !== 1'b0)       begin errors++; $display("FAIL reset_done: got %b want 0", scanDone); end
    if (enableI2C !== 1'b0)      begin errors++; $display("FAIL reset_en: got %b want 0", enableI2C); end
    if (sampleData !== 16'h0)    begin errors++; $display("FAIL reset_data: got %h want 0000", sampleData); end
    if (sampleChannel !== 2'd0)  begin errors++; $display("FAIL reset_chan: got %0d want 0", sampleChannel); end
    if (timeoutError !== 1'b0)   begin errors++; $display("FAIL reset_tmo: got %b want 0", timeoutError); end
    if (instructionI2C !== 2'd0) begin errors++; $display("FAIL reset_instr: got %0d want 0", instructionI2C); end
    if (byteToSendI2C !== 8'h00) begin errors++; $display("FAIL reset_byte: got %h want 00", byteToSendI2C); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_one_pass();
    clear_logs();
    zero_polls = 0;
    continuous = 1'b0;
    enable = 1'b1;
    wait_samples(4, 5000, "one_pass_wait");
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (s_chan[i] !== 2'(i)) begin
        errors++; $display("FAIL one_pass_chan%0d: got %0d want %0d", i, s_chan[i], i);
      end
      if (s_data[i] !== 16'h1234 + 16'(i)) begin
        errors++; $display("FAIL one_pass_data%0d: got %h want %h", i, s_data[i], 16'h1234 + 16'(i));
      end
    end
    checks += 4;
    if (cfg_hi_q[2] !== 8'hE3) begin errors++; $display("FAIL cfg_hi_ch2: got %h want e3", cfg_hi_q[2]); end
    if (cfg_lo_q[2] !== 8'hE3) begin errors++; $display("FAIL cfg_lo_ch2: got %h want e3", cfg_lo_q[2]); end
    if (cfg_hi_q[0] !== 8'hC3) begin errors++; $display("FAIL cfg_hi_ch0: got %h want c3", cfg_hi_q[0]); end
    if (poll_cnt[3] !== 1)     begin errors++; $display("FAIL one_pass_polls: got %0d want 1", poll_cnt[3]); end
    repeat (30) @(negedge clk);
    checks += 4;
    if (busy !== 1'b1)       begin errors++; $display("FAIL done_hold_busy: got %b want 1", busy); end
    if (done_cnt !== 1)      begin errors++; $display("FAIL one_pass_scandone: got %0d want 1", done_cnt); end
    if (s_data.size() !== 4) begin errors++; $display("FAIL one_pass_count: got %0d want 4", s_data.size()); end
    if (addr_bad !== 0)      begin errors++; $display("FAIL addr_byte: bad=%0d want 0", addr_bad); end
    enable = 1'b0;
    wait_idle(10, "one_pass_idle");
  endtask

  task automatic test_slow_poll();
    clear_logs();
    zero_polls = 3;
    enable = 1'b1;
    wait_samples(4, 8000, "slow_poll_wait");
    for (int i = 0; i < 4; i++) begin
      checks += 2;
      if (poll_cnt[i] !== 4) begin
        errors++; $display("FAIL slow_poll_count%0d: got %0d want 4", i, poll_cnt[i]);
      end
      if (s_data[i] !== 16'h1234 + 16'(i)) begin
        errors++; $display("FAIL slow_poll_data%0d: got %h want %h", i, s_data[i], 16'h1234 + 16'(i));
      end
    end
    checks++;
    if (timeoutError !== 1'b0) begin errors++; $display("FAIL slow_poll_tmo: got %b want 0", timeoutError); end
    enable = 1'b0;
    zero_polls = 0;
    wait_idle(20, "slow_poll_idle");
  endtask

  task automatic test_continuous();
    clear_logs();
    continuous = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    continuous = 1'b0;
    wait_samples(5, 8000, "cont_wait");
    enable = 1'b0;
    wait_idle(5000, "cont_idle");
    repeat (50) @(negedge clk);
    checks += 5;
    if (s_data.size() !== 8)  begin errors++; $display("FAIL cont_count: got %0d want 8", s_data.size()); end
    if (done_cnt !== 2)       begin errors++; $display("FAIL cont_scandone: got %0d want 2", done_cnt); end
    if (s_chan[4] !== 2'd0)   begin errors++; $display("FAIL cont_p2_ch0: got %0d want 0", s_chan[4]); end
    if (s_chan[7] !== 2'd3)   begin errors++; $display("FAIL cont_p2_ch3: got %0d want 3", s_chan[7]); end
    if (s_data[7] !== 16'h1237) begin errors++; $display("FAIL cont_p2_data3: got %h want 1237", s_data[7]); end
  endtask

`ifdef ADC_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    stuck_ch = 1;
    enable = 1'b1;
    wait_samples(4, 8000, "tmo_wait");
    checks += 6;
    if (timeoutError !== 1'b1)   begin errors++; $display("FAIL tmo_flag: got %b want 1", timeoutError); end
    if (s_data[1] !== 16'h8000)  begin errors++; $display("FAIL tmo_data1: got %h want 8000", s_data[1]); end
    if (s_chan[1] !== 2'd1)      begin errors++; $display("FAIL tmo_chan1: got %0d want 1", s_chan[1]); end
    if (s_data[2] !== 16'h1236)  begin errors++; $display("FAIL tmo_data2: got %h want 1236", s_data[2]); end
    if (s_data[3] !== 16'h1237)  begin errors++; $display("FAIL tmo_data3: got %h want 1237", s_data[3]); end
    if (poll_cnt[1] !== 4)       begin errors++; $display("FAIL tmo_polls: got %0d want 4", poll_cnt[1]); end
    enable = 1'b0;
    wait_idle(20, "tmo_idle");
    stuck_ch = -1;
    clear_logs();
    enable = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (timeoutError !== 1'b0) begin errors++; $display("FAIL tmo_clear: got %b want 0", timeoutError); end
    wait_samples(4, 5000, "tmo_rescan");
    enable = 1'b0;
    wait_idle(20, "tmo_rescan_idle");
  endtask
`endif

  task automatic test_reset_mid();
    int k;
    clear_logs();
    enable = 1'b1;
    k = 0;
    while (!(enableI2C && instructionI2C == 2'd3 && byteToSendI2C == 8'h01) && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 500) begin errors++; $display("FAIL rst_mid_wait: config write not seen within 500 cycles"); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks += 5;
    if (enableI2C !== 1'b0)     begin errors++; $display("FAIL rst_mid_en: got %b want 0", enableI2C); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    if (sampleData !== 16'h0)   begin errors++; $display("FAIL rst_mid_data: got %h want 0000", sampleData); end
    if (sampleChannel !== 2'd0) begin errors++; $display("FAIL rst_mid_chan: got %0d want 0", sampleChannel); end
    if (byteToSendI2C !== 8'h0) begin errors++; $display("FAIL rst_mid_byte: got %h want 00", byteToSendI2C); end
    repeat (3) @(negedge clk);
    clear_logs();
    rst = 1'b0;
    wait_samples(4, 5000, "rst_mid_rescan");
    checks += 3;
    if (cfg_hi_q[0] !== 8'hC3) begin errors++; $display("FAIL rst_mid_cfg0: got %h want c3", cfg_hi_q[0]); end
    if (s_chan[0] !== 2'd0)    begin errors++; $display("FAIL rst_mid_first_ch: got %0d want 0", s_chan[0]); end
    if (s_data[0] !== 16'h1234) begin errors++; $display("FAIL rst_mid_first_data: got %h want 1234", s_data[0]); end
    enable = 1'b0;
    wait_idle(20, "rst_mid_idle");
  endtask

  initial begin
    test_reset();
    test_one_pass();
    test_slow_poll();
    test_continuous();
`ifdef ADC_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
